// File: rtl/edulent_pkg.sv
// Shared definitions for the edulent memory responder: default widths,
// initial stack pointer and the responder state encoding.
package edulent_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   localparam logic [7:0] SP_INIT = 8'h7F;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_LOAD = 2'd1,
      MS_RUN  = 2'd2
   } mem_state_t;

endpackage

// File: rtl/edulent_ram_1rw.sv
// Single-port-write RAM with a registered, read-first read port.
// The array itself is never reset; only the read register is.
module edulent_ram_1rw
   import edulent_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rdata_r;

   // Storage array write port
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_r[i_waddr] <= i_wdata;
      end
   end

   // Read register; sees the pre-write contents on a same-address write
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rdata_r <= '0;
      end else begin
         rdata_r <= mem_r[i_raddr];
      end
   end

   assign o_rdata = rdata_r;

endmodule

// File: rtl/edulent_mem_responder.sv
// Memory-side responder: 256x8 RAM shared by a boot loader (LOAD) and the
// CPU (RUN), with a write-protect limit and a sticky protection fault.
module edulent_mem_responder
   import edulent_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] PROT_RST = 8'h00
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_boot_en,
   input  logic              i_ld_valid,
   input  logic [DATA_W-1:0] i_ld_data,
   input  logic              i_ld_last,
   output logic              o_ld_ready,
   input  logic              i_prot_wr,
   input  logic [ADDR_W-1:0] i_prot_limit,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic              i_mem_we,
   input  logic [DATA_W-1:0] i_mem_wdata,
   output logic [DATA_W-1:0] o_mem_rdata,
   output logic              o_cpu_rstn,
   output logic              o_wp_fault,
   output logic [ADDR_W:0]   o_load_count
);

   mem_state_t        state_r, state_nxt_s;
   logic [ADDR_W-1:0] ld_ptr_r;
   logic [ADDR_W:0]   load_count_r;
   logic [ADDR_W-1:0] prot_limit_r;
   logic              wp_fault_r;
   logic              cpu_rstn_r;
   logic              ld_ready_r;

   logic              ld_xfer_s;
   logic              ld_done_s;
   logic              cpu_wr_s;
   logic              cpu_viol_s;
   logic              ram_we_s;
   logic [ADDR_W-1:0] ram_waddr_s;
   logic [DATA_W-1:0] ram_wdata_s;

   // A transfer at the top address ends LOAD so the pointer never wraps
   assign ld_xfer_s  = (state_r == MS_LOAD) & i_ld_valid;
   assign ld_done_s  = ld_xfer_s & (i_ld_last | (ld_ptr_r == {ADDR_W{1'b1}}));
   assign cpu_wr_s   = (state_r == MS_RUN) & i_mem_we & (i_mem_addr >= prot_limit_r);
   assign cpu_viol_s = (state_r == MS_RUN) & i_mem_we & (i_mem_addr <  prot_limit_r);

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         MS_IDLE: begin
            if (i_boot_en) state_nxt_s = MS_LOAD;
            else           state_nxt_s = MS_RUN;
         end
         MS_LOAD: begin
            if (ld_done_s) state_nxt_s = MS_RUN;
            else           state_nxt_s = MS_LOAD;
         end
         MS_RUN:  state_nxt_s = MS_RUN;
         default: state_nxt_s = MS_IDLE;
      endcase
   end

   // RAM write port owner: loader during LOAD, CPU otherwise
   always_comb begin
      ram_we_s    = 1'b0;
      ram_waddr_s = '0;
      ram_wdata_s = '0;
      if (state_r == MS_LOAD) begin
         ram_we_s    = ld_xfer_s;
         ram_waddr_s = ld_ptr_r;
         ram_wdata_s = i_ld_data;
      end else begin
         ram_we_s    = cpu_wr_s;
         ram_waddr_s = i_mem_addr;
         ram_wdata_s = i_mem_wdata;
      end
   end

   // State register and registered handshake / CPU reset outputs
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_r    <= MS_IDLE;
         ld_ready_r <= 1'b0;
         cpu_rstn_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         ld_ready_r <= (state_nxt_s == MS_LOAD);
         cpu_rstn_r <= (state_r == MS_RUN);
      end
   end

   // Loader pointer and accepted-byte count
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ld_ptr_r     <= '0;
         load_count_r <= '0;
      end else if ((state_r == MS_IDLE) && (state_nxt_s == MS_LOAD)) begin
         ld_ptr_r     <= '0;
         load_count_r <= '0;
      end else if (ld_xfer_s) begin
         ld_ptr_r     <= ld_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
         load_count_r <= load_count_r + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
         ld_ptr_r     <= ld_ptr_r;
         load_count_r <= load_count_r;
      end
   end

   // Protect limit and sticky fault; a same-cycle write sees the old limit
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         prot_limit_r <= PROT_RST;
         wp_fault_r   <= 1'b0;
      end else begin
         if (i_prot_wr) prot_limit_r <= i_prot_limit;
         else           prot_limit_r <= prot_limit_r;
         if (cpu_viol_s) wp_fault_r <= 1'b1;
         else            wp_fault_r <= wp_fault_r;
      end
   end

   edulent_ram_1rw #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_we    (ram_we_s),
      .i_waddr (ram_waddr_s),
      .i_wdata (ram_wdata_s),
      .i_raddr (i_mem_addr),
      .o_rdata (o_mem_rdata)
   );

   assign o_ld_ready   = ld_ready_r;
   assign o_cpu_rstn   = cpu_rstn_r;
   assign o_wp_fault   = wp_fault_r;
   assign o_load_count = load_count_r;

endmodule

// File: tb/tb_edulent_mem_responder.sv
// Self-checking bench for edulent_mem_responder: random loader/CPU traffic
// compared against an array-based memory model.
module tb_edulent_mem_responder;

   logic       clk = 1'b0;
   logic       rstn;
   logic       boot_en, ld_valid, ld_last, ld_ready;
   logic [7:0] ld_data;
   logic       prot_wr;
   logic [7:0] prot_limit;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata, mem_rdata;
   logic       cpu_rstn, wp_fault;
   logic [8:0] load_count;

   int         vec_cnt = 0;
   int         err_cnt = 0;

   logic [7:0] mem_m [256];
   logic [7:0] lim_m;
   logic       fault_m;

   edulent_mem_responder dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_boot_en    (boot_en),
      .i_ld_valid   (ld_valid),
      .i_ld_data    (ld_data),
      .i_ld_last    (ld_last),
      .o_ld_ready   (ld_ready),
      .i_prot_wr    (prot_wr),
      .i_prot_limit (prot_limit),
      .i_mem_addr   (mem_addr),
      .i_mem_we     (mem_we),
      .i_mem_wdata  (mem_wdata),
      .o_mem_rdata  (mem_rdata),
      .o_cpu_rstn   (cpu_rstn),
      .o_wp_fault   (wp_fault),
      .o_load_count (load_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs(input logic boot);
      boot_en = boot; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
      prot_wr = 1'b0; prot_limit = 8'h00; mem_addr = 8'h00; mem_we = 1'b0;
      mem_wdata = 8'h00;
   endtask

   // Holds reset for two cycles and releases it just after a clock edge
   task automatic apply_reset(input logic boot);
      idle_inputs(boot);
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      lim_m = 8'h00;
      fault_m = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset(1'b0);
      rstn = 1'b0;
      #1;
      vec_cnt++;
      if ({mem_rdata, ld_ready, cpu_rstn, wp_fault, load_count} !== 20'h0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got rdata=%h rdy=%b cpu_rstn=%b fault=%b cnt=%0d, want all zero",
                  mem_rdata, ld_ready, cpu_rstn, wp_fault, load_count);
      end
      rstn = 1'b1;
   endtask

   task automatic test_boot_off();
      apply_reset(1'b0);
      mem_we = 1'b1; mem_addr = 8'h10; mem_wdata = 8'hEE;
      tick();
      mem_we = 1'b0;
      vec_cnt++;
      if (cpu_rstn !== 1'b0 || ld_ready !== 1'b0 || wp_fault !== 1'b0) begin
         err_cnt++;
         $display("FAIL boot_off_entry: got cpu_rstn=%b rdy=%b fault=%b, want 0 0 0", cpu_rstn, ld_ready, wp_fault);
      end
      tick();
      vec_cnt++;
      if (cpu_rstn !== 1'b1 || ld_ready !== 1'b0) begin
         err_cnt++;
         $display("FAIL boot_off_run: got cpu_rstn=%b rdy=%b, want 1 0", cpu_rstn, ld_ready);
      end
   endtask

   task automatic test_load_small();
      logic [7:0] bytes [3];
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      apply_reset(1'b1);
      tick();
      vec_cnt++;
      if (ld_ready !== 1'b1 || cpu_rstn !== 1'b0 || load_count !== 9'd0) begin
         err_cnt++;
         $display("FAIL load_entry: got rdy=%b cpu_rstn=%b cnt=%0d, want 1 0 0", ld_ready, cpu_rstn, load_count);
      end
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1; ld_data = bytes[i]; ld_last = (i == 2);
         mem_m[i] = bytes[i];
         tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      vec_cnt++;
      if (load_count !== 9'd3 || ld_ready !== 1'b0) begin
         err_cnt++;
         $display("FAIL load_small_end: got cnt=%0d rdy=%b, want 3 0", load_count, ld_ready);
      end
      tick();
      vec_cnt++;
      if (cpu_rstn !== 1'b1) begin
         err_cnt++;
         $display("FAIL load_small_run: got cpu_rstn=%b, want 1", cpu_rstn);
      end
      for (int a = 0; a < 3; a++) begin
         mem_addr = 8'(a);
         tick();
         vec_cnt++;
         if (mem_rdata !== mem_m[a]) begin
            err_cnt++;
            $display("FAIL load_small_read[%0d]: got %h, want %h", a, mem_rdata, mem_m[a]);
         end
      end
   endtask

   task automatic test_load_full();
      int ptr = 0;
      int cyc = 0;
      apply_reset(1'b1);
      tick();
      while (ptr < 256 && cyc < 2000) begin
         ld_valid = cyc[0];
         ld_data  = 8'($urandom);
         if (ld_valid && ld_ready) begin
            mem_m[ptr] = ld_data;
            ptr++;
         end
         tick();
         cyc++;
      end
      ld_valid = 1'b0;
      vec_cnt++;
      if (ptr != 256) begin
         err_cnt++;
         $display("FAIL load_full_timeout: accepted %0d bytes, want 256", ptr);
      end
      vec_cnt++;
      if (load_count !== 9'd256 || ld_ready !== 1'b0) begin
         err_cnt++;
         $display("FAIL load_full_end: got cnt=%0d rdy=%b, want 256 0", load_count, ld_ready);
      end
      for (int a = 0; a < 256; a++) begin
         mem_addr = 8'(a);
         tick();
         vec_cnt++;
         if (mem_rdata !== mem_m[a]) begin
            err_cnt++;
            $display("FAIL load_full_read[%0d]: got %h, want %h", a, mem_rdata, mem_m[a]);
         end
      end
      vec_cnt++;
      if (cpu_rstn !== 1'b1 || load_count !== 9'd256) begin
         err_cnt++;
         $display("FAIL load_full_run: got cpu_rstn=%b cnt=%0d, want 1 256", cpu_rstn, load_count);
      end
   endtask

   task automatic test_rw_same_cycle();
      logic [7:0] old_v;
      old_v = mem_m[8'h80];
      mem_addr = 8'h80; mem_we = 1'b1; mem_wdata = 8'hA5;
      tick();
      mem_we = 1'b0;
      mem_m[8'h80] = 8'hA5;
      vec_cnt++;
      if (mem_rdata !== old_v) begin
         err_cnt++;
         $display("FAIL rw_same_cycle_old: got %h, want %h", mem_rdata, old_v);
      end
      tick();
      vec_cnt++;
      if (mem_rdata !== 8'hA5) begin
         err_cnt++;
         $display("FAIL rw_same_cycle_new: got %h, want a5", mem_rdata);
      end
   endtask

   task automatic test_random_run(input int n);
      logic [7:0] a, d, exp_v;
      logic       we;
      for (int i = 0; i < n; i++) begin
         a = 8'($urandom); d = 8'($urandom); we = 1'($urandom);
         exp_v = mem_m[a];
         if (we && a >= lim_m) mem_m[a] = d;
         else if (we)          fault_m = 1'b1;
         mem_addr = a; mem_we = we; mem_wdata = d;
         tick();
         vec_cnt++;
         if (mem_rdata !== exp_v || wp_fault !== fault_m) begin
            err_cnt++;
            $display("FAIL random_run[%0d]: addr=%h got rdata=%h fault=%b, want %h %b",
                     i, a, mem_rdata, wp_fault, exp_v, fault_m);
         end
      end
      mem_we = 1'b0;
   endtask

   task automatic test_protect();
      prot_wr = 1'b1; prot_limit = 8'h40;
      tick();
      prot_wr = 1'b0; lim_m = 8'h40;
      mem_m[8'h3F] = mem_m[8'h3F];
      mem_addr = 8'h3F; mem_we = 1'b1; mem_wdata = ~mem_m[8'h3F];
      tick();
      mem_we = 1'b0;
      vec_cnt++;
      if (wp_fault !== 1'b1) begin
         err_cnt++;
         $display("FAIL protect_fault: got %b, want 1", wp_fault);
      end
      tick();
      vec_cnt++;
      if (mem_rdata !== mem_m[8'h3F]) begin
         err_cnt++;
         $display("FAIL protect_unchanged: got %h, want %h", mem_rdata, mem_m[8'h3F]);
      end
      mem_addr = 8'h40; mem_we = 1'b1; mem_wdata = 8'h5A;
      tick();
      mem_we = 1'b0; mem_m[8'h40] = 8'h5A;
      tick();
      vec_cnt++;
      if (mem_rdata !== 8'h5A || wp_fault !== 1'b1) begin
         err_cnt++;
         $display("FAIL protect_boundary: got rdata=%h fault=%b, want 5a 1", mem_rdata, wp_fault);
      end
      // Limit change and write in the same cycle: write judged against 0x40
      prot_wr = 1'b1; prot_limit = 8'h80;
      mem_addr = 8'h50; mem_we = 1'b1; mem_wdata = 8'hC3;
      tick();
      prot_wr = 1'b0; mem_we = 1'b0; mem_m[8'h50] = 8'hC3; lim_m = 8'h80;
      tick();
      vec_cnt++;
      if (mem_rdata !== 8'hC3) begin
         err_cnt++;
         $display("FAIL protect_old_limit: got %h, want c3", mem_rdata);
      end
      mem_we = 1'b1; mem_wdata = 8'h3C;
      tick();
      mem_we = 1'b0;
      tick();
      vec_cnt++;
      if (mem_rdata !== 8'hC3) begin
         err_cnt++;
         $display("FAIL protect_new_limit: got %h, want c3", mem_rdata);
      end
      fault_m = 1'b1;
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] b0, b1, nb;
      b0 = 8'($urandom); b1 = 8'($urandom); nb = ~b0;
      apply_reset(1'b1);
      tick();
      ld_valid = 1'b1; ld_data = b0;
      mem_we = 1'b1; mem_addr = 8'h90; mem_wdata = ~mem_m[8'h90];
      tick();
      mem_we = 1'b0;
      ld_data = b1;
      tick();
      ld_valid = 1'b0;
      mem_m[0] = b0; mem_m[1] = b1;
      rstn = 1'b0;
      #1;
      vec_cnt++;
      if (ld_ready !== 1'b0 || cpu_rstn !== 1'b0 || wp_fault !== 1'b0) begin
         err_cnt++;
         $display("FAIL mid_load_reset: got rdy=%b cpu_rstn=%b fault=%b, want 0 0 0", ld_ready, cpu_rstn, wp_fault);
      end
      tick();
      rstn = 1'b1;
      tick();
      ld_valid = 1'b1; ld_data = nb; ld_last = 1'b1;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0; mem_m[0] = nb;
      vec_cnt++;
      if (load_count !== 9'd1 || ld_ready !== 1'b0) begin
         err_cnt++;
         $display("FAIL reboot_count: got cnt=%0d rdy=%b, want 1 0", load_count, ld_ready);
      end
      for (int k = 0; k < 3; k++) begin
         mem_addr = (k == 2) ? 8'h90 : 8'(k);
         tick();
         vec_cnt++;
         if (mem_rdata !== mem_m[mem_addr]) begin
            err_cnt++;
            $display("FAIL reboot_read[%h]: got %h, want %h", mem_addr, mem_rdata, mem_m[mem_addr]);
         end
      end
      vec_cnt++;
      if (cpu_rstn !== 1'b1 || wp_fault !== 1'b0) begin
         err_cnt++;
         $display("FAIL reboot_run: got cpu_rstn=%b fault=%b, want 1 0", cpu_rstn, wp_fault);
      end
   endtask

   initial begin
      rstn = 1'b0;
      idle_inputs(1'b0);
      test_reset();
      test_boot_off();
      test_load_small();
      test_load_full();
      test_rw_same_cycle();
      test_random_run(150);
      test_protect();
      test_random_run(150);
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
